// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter onto a single-port RAM, with lock and lock-timeout.
// Latency: command same cycle as accept, response one cycle later; ready is combinational per port.
// Build option DMEM_ARB_RR_EN: round-robin on simultaneous requests (default: port 0 wins).
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  input  logic                req0_we,
  input  logic [ADDR_W-1:0]   req0_addr,
  input  logic [DATA_W-1:0]   req0_wdata,
  input  logic [DATA_W/8-1:0] req0_wstrb,
  input  logic                req0_lock,
  output logic                req0_ready,
  output logic                rsp0_valid,
  output logic [DATA_W-1:0]   rsp0_rdata,
  input  logic                req1_valid,
  input  logic                req1_we,
  input  logic [ADDR_W-1:0]   req1_addr,
  input  logic [DATA_W-1:0]   req1_wdata,
  input  logic [DATA_W/8-1:0] req1_wstrb,
  input  logic                req1_lock,
  output logic                req1_ready,
  output logic                rsp1_valid,
  output logic [DATA_W-1:0]   rsp1_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata
);

  typedef enum logic [1:0] {OPEN, LOCK0, LOCK1} state_t;

  state_t     state;
  logic       last_grant;
  logic [3:0] idle_cnt;
  logic [1:0] rsp_pend;
  logic       rsp_rd;
  logic       gnt0;
  logic       gnt1;

  // Grants are gated by rst so every output is 0 the moment reset asserts.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst) begin
      case (state)
        LOCK0: gnt0 = req0_valid;
        LOCK1: gnt1 = req1_valid;
        default: begin
          if (req0_valid && req1_valid) begin
`ifdef DMEM_ARB_RR_EN
            gnt0 = last_grant;
            gnt1 = ~last_grant;
`else
            gnt0 = 1'b1;
`endif
          end else begin
            gnt0 = req0_valid;
            gnt1 = req1_valid;
          end
        end
      endcase
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_comb begin
    mem_en    = gnt0 | gnt1;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (gnt0) begin
      mem_we    = req0_we;
      mem_addr  = req0_addr;
      mem_wdata = req0_wdata;
      mem_wstrb = req0_wstrb;
    end else if (gnt1) begin
      mem_we    = req1_we;
      mem_addr  = req1_addr;
      mem_wdata = req1_wdata;
      mem_wstrb = req1_wstrb;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= OPEN;
      last_grant <= 1'b1;
      idle_cnt   <= 4'd0;
      rsp_pend   <= 2'b00;
      rsp_rd     <= 1'b0;
    end else begin
      rsp_pend   <= {gnt1, gnt0};
      rsp_rd     <= mem_en & ~mem_we;
      last_grant <= mem_en ? gnt1 : last_grant;
      if (gnt0) begin
        state    <= req0_lock ? LOCK0 : OPEN;
        idle_cnt <= 4'd0;
      end else if (gnt1) begin
        state    <= req1_lock ? LOCK1 : OPEN;
        idle_cnt <= 4'd0;
      end else if (state != OPEN) begin
        // No grant while locked means the owner is idle; release after 16 such cycles.
        if (idle_cnt == 4'd15) begin
          state    <= OPEN;
          idle_cnt <= 4'd0;
        end else begin
          idle_cnt <= idle_cnt + 4'd1;
        end
      end
    end
  end

  assign rsp0_valid = rsp_pend[0];
  assign rsp1_valid = rsp_pend[1];
  assign rsp0_rdata = (rsp_pend[0] && rsp_rd) ? mem_rdata : '0;
  assign rsp1_rdata = (rsp_pend[1] && rsp_rd) ? mem_rdata : '0;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; byte strobe width is DATA_W/8.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports reqN_valid  input  1  request from port N (N=0 core load/store, N=1 debug/loader).
REQ-006 SHALL have ports reqN_we / reqN_addr / reqN_wdata / reqN_wstrb  input  1 / ADDR_W / DATA_W / DATA_W/8  write flag, address, write data, byte enables.
REQ-007 SHALL have ports reqN_lock  input  1  hold the grant after this access (read-modify-write sequence).
REQ-008 SHALL have ports reqN_ready  output  1  the request is accepted this cycle.
REQ-009 SHALL have ports rspN_valid / rspN_rdata  output  1 / DATA_W  completion strobe and read data.
REQ-010 SHALL have ports mem_en / mem_we / mem_addr / mem_wdata / mem_wstrb  output  1 / 1 / ADDR_W / DATA_W / DATA_W/8  single-port memory command.
REQ-011 SHALL have port mem_rdata  input  DATA_W  memory read data, valid the cycle after a read command.

Function
REQ-012 SHALL issue at most one memory command per cycle; a request is accepted when reqN_valid and reqN_ready are both high.
REQ-013 SHALL drive reqN_ready combinationally; at most one ready is high per cycle.
REQ-014 SHALL drive mem_* combinationally from the accepted port; mem_en SHALL be 0 when no port is accepted, and mem_we/mem_wstrb SHALL then be 0.
REQ-015 SHALL assert rspN_valid for exactly one cycle, in the cycle after acceptance, for both reads and writes.
REQ-016 SHALL drive rspN_rdata from mem_rdata during a read response and 0 otherwise.
REQ-017 SHALL sustain one accepted request per cycle (no bubbles) while requests are pending.
REQ-018 SHALL implement FSM states OPEN, LOCK0 and LOCK1.
REQ-019 In OPEN, with one port valid, SHALL grant that port.
REQ-020 In OPEN, with both ports valid, SHALL grant per the arbitration policy (REQ-029/030).
REQ-021 On acceptance with reqN_lock=1 SHALL go to LOCKN; with reqN_lock=0 SHALL go to or stay in OPEN.
REQ-022 In LOCKN, only port N may be granted; the other port's ready SHALL stay 0 even while port N is idle.
REQ-023 In LOCKN, an accepted port-N request with lock=0 SHALL return the FSM to OPEN next cycle.
REQ-024 SHALL go from LOCKN to OPEN when reqN_valid is 0 for 16 consecutive cycles (lock timeout); a 4-bit idle counter SHALL clear on any port-N acceptance.
REQ-025 SHALL keep a last_grant bit, updated on every acceptance.

Reset
REQ-026 Assertion of rst (low) SHALL immediately force: FSM=OPEN, last_grant=1, idle counter=0, pending response cleared.
REQ-027 During reset all outputs SHALL be 0: ready, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb.
REQ-028 A request accepted in the cycle before reset asserts SHALL produce no response; no rspN_valid SHALL be emitted after rst deasserts without a new acceptance.

Configuration
REQ-029 With DMEM_ARB_RR_EN defined, simultaneous requests in OPEN SHALL be granted round-robin: the port that was not last_grant wins.
REQ-030 Without DMEM_ARB_RR_EN, port 0 SHALL always win simultaneous requests in OPEN; last_grant SHALL still be maintained but SHALL not affect arbitration.

Verification
REQ-031 Port 0 only: write addr 0x10, data 0xDEADBEEF, strb 0xF; then read 0x10 -> ready0 high both cycles, rsp0_valid on each following cycle, second rsp0_rdata = 0xDEADBEEF.
REQ-032 Both ports valid for 4 cycles with RR_EN -> grants 0,1,0,1 (last_grant reset = 1); without RR_EN -> grants 0,0,0,0 and ready1 = 0 throughout.
REQ-033 Port 1 read with lock=1 at 0x20, then port 0 valid for 5 cycles, then port 1 write with lock=0 -> ready0 = 0 until the cycle after the port-1 write; the FSM then returns to OPEN and port 0 is granted.
REQ-034 Port 0 lock=1 read, then port 0 idle for 16 cycles while port 1 is valid -> ready1 stays 0 for cycles 1-16 and is granted on cycle 17.
REQ-035 rst pulsed low mid-stream during back-to-back port-0 reads -> all outputs are 0 asynchronously, and no rsp0_valid occurs after release until a new request is accepted.
REQ-036 Byte write with strb 0x2, data 0x0000AB00, to a word holding 0x11223344 -> mem_wstrb = 0x2 and mem_we = 1; a following read returns 0x1122AB44.
